iomem_dbg_master: RTL and testbench



---
 rtl/iomem_dbg_pkg.sv | 20 ++
 rtl/dbg_tx_shifter.sv | 52 +++++
 rtl/iomem_dbg_master.sv | 188 ++++++++++++++++++
 tb/tb_iomem_dbg_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_dbg_pkg.sv
// iomem_dbg_pkg: shared constants and types for the iomem debug master.
//   CMD_READ / CMD_WRITE   : command opcodes received on the byte stream
//   RSP_OK / RSP_TIMEOUT   : response status bytes
//   dbg_state_t            : master FSM state encoding
package iomem_dbg_pkg;

    localparam logic [7:0] CMD_READ    = 8'h52;   // 'R'
    localparam logic [7:0] CMD_WRITE   = 8'h57;   // 'W'
    localparam logic [7:0] RSP_OK      = 8'h4B;   // 'K'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;   // 'T'

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        TX   = 3'd4
    } dbg_state_t;

endpackage

// File: rtl/dbg_tx_shifter.sv
// dbg_tx_shifter: load-and-shift response register, 1..5 bytes, LSB byte first.
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   load                   : load load_data/load_len (only issued while idle)
//   load_len [2:0]         : number of bytes to send (1..5)
//   load_data [39:0]       : byte 0 in [7:0], byte 1 in [15:8], ...
//   tx_ready               : downstream accepts tx_data when tx_valid is high
//   tx_valid, tx_data [7:0]: current response byte, held until accepted
//   last                   : the byte on tx_data is the final one
module dbg_tx_shifter
    import iomem_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [2:0]  load_len,
    input  logic [39:0] load_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        last
);

    logic [39:0] shreg;
    logic [2:0]  left;

    // Load a response, then drop one byte per accepted handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            shreg    <= 40'd0;
            left     <= 3'd0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shreg    <= load_data;
            left     <= load_len;
            tx_valid <= (load_len != 3'd0);
        end else if (tx_valid && tx_ready) begin
            // Shifting zeros in leaves tx_data at 0 once the response is done.
            shreg    <= {8'h00, shreg[39:8]};
            left     <= left - 3'd1;
            tx_valid <= (left != 3'd1);
        end else begin
            shreg    <= shreg;
            left     <= left;
            tx_valid <= tx_valid;
        end
    end

    assign tx_data = shreg[7:0];
    assign last    = (left == 3'd1);

endmodule

// File: rtl/iomem_dbg_master.sv
// iomem_dbg_master: byte-stream debug initiator for the iomem peripheral bus.
// Receives 'R' + addr[4] or 'W' + addr[4] + data[4] (little-endian), runs one
// iomem transaction and answers 'K' (+ rdata[4] for reads) on the tx stream.
// Optional macro IOMEM_DBG_TIMEOUT_EN: abort a bus cycle after TIMEOUT_CYCLES
// cycles without iomem_ready and answer 'T'.
// Ports:
//   clk, resetn                   : clock, synchronous active-low reset
//   rx_valid, rx_data [7:0]       : received byte strobe and value
//   tx_valid, tx_ready, tx_data   : response byte handshake
//   iomem_valid/ready/wstrb/addr/wdata/rdata : bus initiator interface
//   busy                          : FSM is not in IDLE
//   rx_drop                       : rx byte discarded (received during BUS/TX)
module iomem_dbg_master
    import iomem_dbg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_BITS        = 11
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy,
    output logic        rx_drop
);

    dbg_state_t  state;
    logic        is_write;
    logic [1:0]  cnt;
    logic        tx_load;
    logic [2:0]  tx_len;
    logic [39:0] tx_bytes;
    logic        tx_last;
    logic        to_expire;

`ifdef IOMEM_DBG_TIMEOUT_EN
    logic [TO_BITS-1:0] to_cnt;

    // Bus-wait counter: zero outside BUS, counts BUS cycles without ready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if (state != BUS) begin
            to_cnt <= '0;
        end else if (!iomem_ready && !to_expire) begin
            to_cnt <= to_cnt + TO_BITS'(1);
        end else begin
            to_cnt <= to_cnt;
        end
    end

    assign to_expire = (state == BUS) && (to_cnt == TO_BITS'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(TIMEOUT_CYCLES) ^ 32'(TO_BITS);
    assign to_expire  = 1'b0;
`endif

    // Select the response to load into the tx shifter when BUS finishes.
    always_comb begin
        tx_load  = 1'b0;
        tx_len   = 3'd0;
        tx_bytes = 40'd0;
        if (state == BUS && iomem_ready) begin
            tx_load = 1'b1;
            if (is_write) begin
                tx_len   = 3'd1;
                tx_bytes = {32'd0, RSP_OK};
            end else begin
                tx_len   = 3'd5;
                tx_bytes = {iomem_rdata, RSP_OK};
            end
        end else if (to_expire) begin
            // Ready in the same cycle takes the branch above instead.
            tx_load  = 1'b1;
            tx_len   = 3'd1;
            tx_bytes = {32'd0, RSP_TIMEOUT};
        end else begin
            tx_load = 1'b0;
        end
    end

    // Command decode, field collection and bus handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            cnt         <= 2'd0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= 4'h0;
            iomem_addr  <= 32'd0;
            iomem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
                        is_write <= (rx_data == CMD_WRITE);
                        cnt      <= 2'd0;
                        state    <= ADDR;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        // Little-endian: each new byte enters at the top.
                        iomem_addr <= {rx_data, iomem_addr[31:8]};
                        cnt        <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (is_write) begin
                                state <= DATA;
                            end else begin
                                state       <= BUS;
                                iomem_valid <= 1'b1;
                                iomem_wstrb <= 4'h0;
                            end
                        end else begin
                            state <= ADDR;
                        end
                    end else begin
                        state <= ADDR;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        iomem_wdata <= {rx_data, iomem_wdata[31:8]};
                        cnt         <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state       <= BUS;
                            iomem_valid <= 1'b1;
                            iomem_wstrb <= 4'hF;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        state <= DATA;
                    end
                end
                BUS: begin
                    if (iomem_ready || to_expire) begin
                        iomem_valid <= 1'b0;
                        iomem_wstrb <= 4'h0;
                        state       <= TX;
                    end else begin
                        state <= BUS;
                    end
                end
                TX: begin
                    if (tx_valid && tx_ready && tx_last) begin
                        state <= IDLE;
                    end else begin
                        state <= TX;
                    end
                end
                default: begin
                    state       <= IDLE;
                    iomem_valid <= 1'b0;
                    iomem_wstrb <= 4'h0;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign rx_drop = rx_valid && (state == BUS || state == TX);

    dbg_tx_shifter u_tx (
        .clk       (clk),
        .resetn    (resetn),
        .load      (tx_load),
        .load_len  (tx_len),
        .load_data (tx_bytes),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .last      (tx_last)
    );

endmodule

// File: tb/tb_iomem_dbg_master.sv
// tb_iomem_dbg_master: directed table-driven bench for iomem_dbg_master.
module tb_iomem_dbg_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        iomem_valid;
    logic        iomem_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata = 32'hDEADDEAD;
    logic        busy;
    logic        rx_drop;

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;

    // rx byte i is rx[i], tx byte i is tx[i] (index 0 = first on the wire).
    typedef struct packed {
        int               nrx;
        logic [8:0][7:0]  rx;
        logic [31:0]      exp_addr;
        logic [31:0]      exp_wdata;
        logic [3:0]       exp_wstrb;
        logic [31:0]      rdata;
        int               delay;
        int               stall;
        int               ntx;
        logic [4:0][7:0]  tx;
    } vec_t;

    vec_t vecs [5];

    iomem_dbg_master #(.TIMEOUT_CYCLES(16), .TO_BITS(5)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy),
        .rx_drop     (rx_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic recv(input string name, input int ntx, input logic [4:0][7:0] tx, input int stall);
        int bad;
        bad = 0;
        for (int b = 0; b < ntx; b++) begin
            for (int s = 0; s < stall; s++) begin
                tx_ready = 1'b0;
                if (!tx_valid || tx_data !== tx[b]) bad++;
                tick();
            end
            check($sformatf("%s tx_valid[%0d]", name, b), 64'(tx_valid), 64'd1);
            check($sformatf("%s tx_byte[%0d]", name, b), 64'(tx_data), 64'(tx[b]));
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
        end
        check({name, " stall_stable"}, 64'(bad), 64'd0);
        check({name, " idle_after"}, 64'({tx_valid, busy}), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int held;
        for (int i = 0; i < v.nrx; i++) send_byte(v.rx[i]);
        check({name, " valid_rise"}, 64'({iomem_valid, busy}), 64'b11);
        check({name, " addr"}, 64'(iomem_addr), 64'(v.exp_addr));
        check({name, " wstrb"}, 64'(iomem_wstrb), 64'(v.exp_wstrb));
        if (v.exp_wstrb == 4'hF) check({name, " wdata"}, 64'(iomem_wdata), 64'(v.exp_wdata));
        held = 1;
        for (int d = 0; d < v.delay; d++) begin
            tick();
            if (iomem_valid && iomem_addr == v.exp_addr && iomem_wstrb == v.exp_wstrb) held++;
        end
        iomem_ready = 1'b1;
        iomem_rdata = v.rdata;
        tick();
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEADDEAD;
        check({name, " valid_cycles"}, 64'(held), 64'(v.delay + 1));
        check({name, " valid_drop"}, 64'({iomem_valid, tx_valid}), 64'b01);
        recv(name, v.ntx, v.tx, v.stall);
    endtask

    initial begin
        vec_t sv;
        int cnt;
        logic [4:0][7:0] exp_tx;

        // Read of 0x03000004, response with backpressure.
        vecs[0] = '{nrx: 5, rx: {32'd0, 8'h03, 8'h00, 8'h00, 8'h04, 8'h52},
                    exp_addr: 32'h0300_0004, exp_wdata: 32'd0, exp_wstrb: 4'h0,
                    rdata: 32'h1234_5678, delay: 3, stall: 10, ntx: 5,
                    tx: {8'h12, 8'h34, 8'h56, 8'h78, 8'h4B}};
        // Write 0x21 to 0x03000000.
        vecs[1] = '{nrx: 9, rx: {8'h00, 8'h00, 8'h00, 8'h21, 8'h03, 8'h00, 8'h00, 8'h00, 8'h57},
                    exp_addr: 32'h0300_0000, exp_wdata: 32'h0000_0021, exp_wstrb: 4'hF,
                    rdata: 32'hFFFF_FFFF, delay: 0, stall: 0, ntx: 1,
                    tx: {32'd0, 8'h4B}};
        // Garbage bytes 00 FF ahead of a read of 0x03000010.
        vecs[2] = '{nrx: 7, rx: {16'd0, 8'h03, 8'h00, 8'h00, 8'h10, 8'h52, 8'hFF, 8'h00},
                    exp_addr: 32'h0300_0010, exp_wdata: 32'd0, exp_wstrb: 4'h0,
                    rdata: 32'hA5A5_0F0F, delay: 1, stall: 0, ntx: 5,
                    tx: {8'hA5, 8'hA5, 8'h0F, 8'h0F, 8'h4B}};
        // Write with all address/data bytes distinct.
        vecs[3] = '{nrx: 9, rx: {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h57},
                    exp_addr: 32'h1234_5678, exp_wdata: 32'hDEAD_BEEF, exp_wstrb: 4'hF,
                    rdata: 32'h0, delay: 2, stall: 2, ntx: 1,
                    tx: {32'd0, 8'h4B}};
        // Read with a longer bus wait and one-cycle stalls.
        vecs[4] = '{nrx: 5, rx: {32'd0, 8'h03, 8'h00, 8'h01, 8'h00, 8'h52},
                    exp_addr: 32'h0300_0100, exp_wdata: 32'd0, exp_wstrb: 4'h0,
                    rdata: 32'hCAFE_F00D, delay: 5, stall: 1, ntx: 5,
                    tx: {8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h4B}};

        repeat (3) tick();
        check("reset_outputs",
              64'({tx_valid, tx_data, iomem_valid, iomem_wstrb, busy, rx_drop}), 64'd0);
        check("reset_addr_wdata", {iomem_addr, iomem_wdata}, 64'd0);
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
        check("no_drop_in_idle_cmd", 64'(drop_cnt), 64'd0);

        // Stray bytes: one in the ready cycle, one during TX.
        sv = vecs[0];
        sv.rx = {32'd0, 8'h03, 8'h00, 8'h00, 8'h08, 8'h52};
        for (int i = 0; i < 5; i++) send_byte(sv.rx[i]);
        check("stray addr", 64'(iomem_addr), 64'h0300_0008);
        tick();
        iomem_ready = 1'b1;
        iomem_rdata = 32'h89AB_CDEF;
        rx_valid    = 1'b1;
        rx_data     = 8'h57;
        #1;
        check("stray drop_with_ready", 64'(rx_drop), 64'd1);
        tick();
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEADDEAD;
        rx_valid    = 1'b0;
        check("stray bus_done", 64'({iomem_valid, tx_valid, busy}), 64'b011);
        rx_valid = 1'b1;
        rx_data  = 8'h52;
        #1;
        check("stray drop_in_tx", 64'(rx_drop), 64'd1);
        tick();
        rx_valid = 1'b0;
        exp_tx = {8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h4B};
        recv("stray", 5, exp_tx, 3);
        check("stray drop_count", 64'(drop_cnt), 64'd2);

        // Reset while the bus request is outstanding.
        for (int i = 0; i < 5; i++) send_byte(sv.rx[i]);
        tick();
        check("rst busy_before", 64'({iomem_valid, busy}), 64'b11);
        resetn = 1'b0;
        tick();
        check("rst outputs", 64'({iomem_valid, busy, tx_valid}), 64'd0);
        resetn = 1'b1;
        tick();
        run_vec(vecs[0], "after_rst");

`ifdef IOMEM_DBG_TIMEOUT_EN
        // Ready never arrives: valid for 16 cycles, then 'T'.
        for (int i = 0; i < 5; i++) send_byte(vecs[0].rx[i]);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (!iomem_valid) break;
            cnt++;
            tick();
        end
        check("timeout valid_cycles", 64'(cnt), 64'd16);
        exp_tx = {32'd0, 8'h54};
        recv("timeout", 1, exp_tx, 0);
`else
        cnt = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
